// File: rtl/mul_share_arbiter_if.sv
// mul_share_arbiter_if: requester, multiplier and response bus of the
// shared-multiplier arbiter. slave = arbiter side, master = cluster side.
interface mul_share_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int IA_W  = 16,
  parameter int IB_W  = 16,
  parameter int MUL_W = 32,
  parameter int ID_W  = $clog2(N_REQ)
);
  logic [N_REQ-1:0]      i_req_valid;
  logic [N_REQ-1:0]      o_req_ready;
  logic [N_REQ*IA_W-1:0] i_req_a;
  logic [N_REQ*IB_W-1:0] i_req_b;
  logic [IA_W-1:0]       o_mul_a;
  logic [IB_W-1:0]       o_mul_b;
  logic                  o_mul_en;
  logic [MUL_W-1:0]      i_mul_prod;
  logic [N_REQ-1:0]      o_rsp_valid;
  logic [ID_W-1:0]       o_rsp_id;
  logic [MUL_W-1:0]      o_rsp_prod;

  modport slave (
    input  i_req_valid, i_req_a, i_req_b, i_mul_prod,
    output o_req_ready, o_mul_a, o_mul_b, o_mul_en,
           o_rsp_valid, o_rsp_id, o_rsp_prod
  );

  modport master (
    output i_req_valid, i_req_a, i_req_b, i_mul_prod,
    input  o_req_ready, o_mul_a, o_mul_b, o_mul_en,
           o_rsp_valid, o_rsp_id, o_rsp_prod
  );
endinterface

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin sharing of one multiplier among N_REQ
// requesters. Grants are combinational, operands are registered into the
// multiplier, an ID tag pipeline of MUL_LAT+1 stages follows each issue and
// the product comes back as a one-cycle one-hot response pulse.
// Optional macro MUL_SHARE_BUSY_CNT_EN: saturating issue-cycle counter on
// o_busy_cnt; without it o_busy_cnt is tied to zero.
module mul_share_arbiter #(
  parameter int N_REQ   = 4,
  parameter int IA_W    = 16,
  parameter int IB_W    = 16,
  parameter int MUL_W   = 32,
  parameter int MUL_LAT = 2,
  parameter int ID_W    = $clog2(N_REQ)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_hold,
  mul_share_arbiter_if.slave  bus,
  output logic                o_idle,
  output logic [31:0]         o_busy_cnt
);

  logic [ID_W-1:0]        r_ptr;
  logic [IA_W-1:0]        r_mul_a;
  logic [IB_W-1:0]        r_mul_b;
  logic                   r_mul_en;
  logic [MUL_LAT:0]       r_tag_vld;
  logic [MUL_LAT:0][ID_W-1:0] r_tag_id;
  logic [N_REQ-1:0]       r_rsp_valid;
  logic [ID_W-1:0]        r_rsp_id;
  logic [MUL_W-1:0]       r_rsp_prod;

  logic                   w_found;
  logic [ID_W-1:0]        w_gnt_id;
  logic                   w_hs;
  logic [N_REQ-1:0]       w_ready;
  logic [N_REQ-1:0]       w_rsp_oh;

  // Round-robin search from r_ptr upward, wrapping at N_REQ
  always_comb begin
    int w_idx;
    w_found  = 1'b0;
    w_gnt_id = '0;
    w_idx    = 0;
    for (int off = 0; off < N_REQ; off++) begin
      w_idx = int'(r_ptr) + off;
      if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
      if (!w_found && bus.i_req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_gnt_id = ID_W'(w_idx);
      end
    end
  end

  // Grant is suppressed by hold and while reset is asserted
  assign w_hs = w_found & ~i_hold & ~i_rst;

  // One-hot ready for the winning requester
  always_comb begin
    w_ready = '0;
    if (w_hs) w_ready[w_gnt_id] = 1'b1;
  end

  // Issue stage: capture granted operands, advance pointer past the winner
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr    <= '0;
      r_mul_a  <= '0;
      r_mul_b  <= '0;
      r_mul_en <= 1'b0;
    end else begin
      r_mul_en <= w_hs;
      if (w_hs) begin
        r_ptr   <= (w_gnt_id == ID_W'(N_REQ-1)) ? '0 : w_gnt_id + 1'b1;
        r_mul_a <= bus.i_req_a[w_gnt_id*IA_W +: IA_W];
        r_mul_b <= bus.i_req_b[w_gnt_id*IB_W +: IB_W];
      end
    end
  end

  // Tag pipeline: stage 0 aligns with o_mul_en, last stage with a valid product
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tag_vld <= '0;
      r_tag_id  <= '0;
    end else begin
      r_tag_vld[0] <= w_hs;
      r_tag_id[0]  <= w_gnt_id;
      for (int i = 1; i <= MUL_LAT; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_id[i]  <= r_tag_id[i-1];
      end
    end
  end

  // Decode the returning tag into a one-hot response vector
  always_comb begin
    w_rsp_oh = '0;
    w_rsp_oh[r_tag_id[MUL_LAT]] = 1'b1;
  end

  // Response register: pulse valid for one cycle, keep id/product afterwards
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rsp_valid <= '0;
      r_rsp_id    <= '0;
      r_rsp_prod  <= '0;
    end else begin
      r_rsp_valid <= '0;
      if (r_tag_vld[MUL_LAT]) begin
        r_rsp_valid <= w_rsp_oh;
        r_rsp_id    <= r_tag_id[MUL_LAT];
        r_rsp_prod  <= bus.i_mul_prod;
      end
    end
  end

`ifdef MUL_SHARE_BUSY_CNT_EN
  logic [31:0] r_busy_cnt;

  // Count issue cycles, saturating at all-ones
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_busy_cnt <= '0;
    else if (r_mul_en && (r_busy_cnt != 32'hFFFF_FFFF))
      r_busy_cnt <= r_busy_cnt + 32'd1;
  end

  assign o_busy_cnt = r_busy_cnt;
`else
  assign o_busy_cnt = 32'd0;
`endif

  assign bus.o_req_ready = w_ready;
  assign bus.o_mul_a     = r_mul_a;
  assign bus.o_mul_b     = r_mul_b;
  assign bus.o_mul_en    = r_mul_en;
  assign bus.o_rsp_valid = r_rsp_valid;
  assign bus.o_rsp_id    = r_rsp_id;
  assign bus.o_rsp_prod  = r_rsp_prod;
  assign o_idle          = ~(|r_tag_vld) & ~(|r_rsp_valid);

endmodule
